// File: rtl/ysyx_041461_pipe_stage_pkg.sv
// Shared pipeline-stage definitions: occupancy state encoding plus per-stage
// payload widths and reset payloads used by the stage wrappers.
package ysyx_041461_pipe_stage_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } ps_state_e;

  localparam int unsigned IF_DATA_W  = 96;
  localparam int unsigned ID_DATA_W  = 160;
  localparam int unsigned EXE_DATA_W = 224;
  localparam int unsigned MEM_DATA_W = 200;
  localparam int unsigned WB_DATA_W  = 136;

  localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [IF_DATA_W-1:0] IF_RESET_DATA = {PC_RESET, NOP_INST};

  // The state encoding equals the number of held entries.
  function automatic logic [1:0] ps_occ(input ps_state_e s);
    return s;
  endfunction

endpackage

// File: rtl/ysyx_041461_pipe_slot.sv
// One payload register with load enable; async reset loads RESET_DATA.
module ysyx_041461_pipe_slot #(
  parameter int unsigned          DATA_W     = 64,
  parameter logic [DATA_W-1:0]    RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (ld) data_d = d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_q <= RESET_DATA;
    else      data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/ysyx_041461_pipe_stage.sv
// Valid/ready pipeline stage register with flush; SKID=1 adds a second entry
// so that in_ready comes straight from a flop.
module ysyx_041461_pipe_stage
  import ysyx_041461_pipe_stage_pkg::*;
#(
  parameter int unsigned       DATA_W     = 64,
  parameter logic [DATA_W-1:0] RESET_DATA = '0,
  parameter bit                SKID       = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  logic              in_fire;
  logic              out_fire;
  logic              m_ld;
  logic [DATA_W-1:0] m_d;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  ysyx_041461_pipe_slot #(.DATA_W(DATA_W), .RESET_DATA(RESET_DATA)) u_slot_m (
    .clk (clk),
    .rst (rst),
    .ld  (m_ld),
    .d   (m_d),
    .q   (out_data)
  );

  generate
    if (SKID) begin : g_skid
      ps_state_e         state_q, state_d;
      logic              in_ready_q, in_ready_d;
      logic              s_ld;
      logic [DATA_W-1:0] s_q;

      ysyx_041461_pipe_slot #(.DATA_W(DATA_W), .RESET_DATA(RESET_DATA)) u_slot_s (
        .clk (clk),
        .rst (rst),
        .ld  (s_ld),
        .d   (in_data),
        .q   (s_q)
      );

      always_comb begin
        state_d = state_q;
        m_ld    = 1'b0;
        s_ld    = 1'b0;
        m_d     = (state_q == PS_TWO) ? s_q : in_data;
        unique case (state_q)
          PS_EMPTY: if (in_fire) begin
            state_d = PS_ONE;
            m_ld    = 1'b1;
          end
          PS_ONE: begin
            if (in_fire && out_fire) begin
              m_ld = 1'b1;
            end else if (in_fire) begin
              state_d = PS_TWO;
              s_ld    = 1'b1;
            end else if (out_fire) begin
              state_d = PS_EMPTY;
            end
          end
          PS_TWO: if (out_fire) begin
            state_d = PS_ONE;
            m_ld    = 1'b1;
          end
          default: state_d = PS_EMPTY;
        endcase
        // Flush drops held entries and any beat accepted this cycle; payloads stay put.
        if (flush) begin
          state_d = PS_EMPTY;
          m_ld    = 1'b0;
          s_ld    = 1'b0;
        end
        in_ready_d = (state_d != PS_TWO);
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_q    <= PS_EMPTY;
          in_ready_q <= 1'b1;
        end else begin
          state_q    <= state_d;
          in_ready_q <= in_ready_d;
        end
      end

      assign in_ready  = in_ready_q;
      assign out_valid = (state_q != PS_EMPTY);
      assign occ       = ps_occ(state_q);
    end else begin : g_pass
      logic valid_q, valid_d;

      always_comb begin
        valid_d = valid_q;
        if (in_fire)       valid_d = 1'b1;
        else if (out_fire) valid_d = 1'b0;
        if (flush)         valid_d = 1'b0;
        m_ld = in_fire & ~flush;
        m_d  = in_data;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) valid_q <= 1'b0;
        else      valid_q <= valid_d;
      end

      assign in_ready  = ~valid_q | out_ready;
      assign out_valid = valid_q;
      assign occ       = {1'b0, valid_q};
    end
  endgenerate

endmodule
